// File: rtl/plot_scheduler_pkg.sv
// Shared splatoon constants: screen geometry, colour codes, requester indices
// and the plot scheduler state encoding.
package plot_scheduler_pkg;

    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;

    localparam logic [2:0] COL_BG    = 3'b000;
    localparam logic [2:0] COL_P1    = 3'b001;
    localparam logic [2:0] COL_P2    = 3'b010;
    localparam logic [2:0] COL_P3    = 3'b100;
    localparam logic [2:0] COL_P4    = 3'b110;
    localparam logic [2:0] COL_TIMER = 3'b111;

    typedef enum int {
        REQ_P1    = 0,
        REQ_P2    = 1,
        REQ_P3    = 2,
        REQ_P4    = 3,
        REQ_TIMER = 4
    } req_idx_e;

    localparam int NUM_PLOT_REQ = 5;

    localparam logic [0:0] ST_ARB   = 1'b0;
    localparam logic [0:0] ST_CLEAR = 1'b1;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first set bit of eff searching from ptr
// upwards, wrapping modulo NUM_REQ (which need not be a power of two).
module rr_picker #(
    parameter int NUM_REQ = 5,
    parameter int PTR_W   = 3
) (
    input  logic [NUM_REQ-1:0] eff,
    input  logic [PTR_W-1:0]   ptr,
    output logic [PTR_W-1:0]   winner,
    output logic               valid
);

    logic [PTR_W:0]   sum [NUM_REQ];
    logic [PTR_W-1:0] idx [NUM_REQ];

    // idx[gi] is the requester examined gi places after ptr
    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_idx
            assign sum[gi] = {1'b0, ptr} + (PTR_W+1)'(gi);
            assign idx[gi] = (sum[gi] >= (PTR_W+1)'(NUM_REQ))
                           ? PTR_W'(sum[gi] - (PTR_W+1)'(NUM_REQ))
                           : sum[gi][PTR_W-1:0];
        end
    endgenerate

    // Scan from the far end so the position closest to ptr wins last.
    always_comb begin
        winner = '0;
        valid  = 1'b0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (eff[idx[k]]) begin
                winner = idx[k];
                valid  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/plot_scheduler.sv
// Shares the vga_adapter plot port between the player heads and the timer bar
// (one pixel per cycle, round robin) and runs the full-screen clear sweep.
module plot_scheduler #(
    parameter int         NUM_REQ      = 5,
    parameter int         SCREEN_W     = plot_scheduler_pkg::SCREEN_W,
    parameter int         SCREEN_H     = plot_scheduler_pkg::SCREEN_H,
    parameter logic [2:0] CLEAR_COLOUR = 3'b000
) (
    input  logic                 CLOCK_50,
    input  logic                 resetn,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [8*NUM_REQ-1:0] req_x,
    input  logic [7*NUM_REQ-1:0] req_y,
    input  logic [3*NUM_REQ-1:0] req_colour,
    output logic [NUM_REQ-1:0]   grant,
    input  logic                 clear_start,
    output logic                 clear_busy,
    output logic                 clear_done,
    output logic [7:0]           x,
    output logic [6:0]           y,
    output logic [2:0]           colour,
    output logic                 plot
);

    import plot_scheduler_pkg::*;

    localparam int         PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [7:0] CX_LAST = 8'(SCREEN_W - 1);
    localparam logic [6:0] CY_LAST = 7'(SCREEN_H - 1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(NUM_REQ - 1);

    logic [0:0]         state_reg;
    logic [PTR_W-1:0]   ptr_reg;
    logic [7:0]         cx_reg;
    logic [6:0]         cy_reg;
    logic               clear_last_reg;

    logic [NUM_REQ-1:0] eff;
    logic [PTR_W-1:0]   pick_idx;
    logic               pick_valid;
    logic [PTR_W-1:0]   ptr_next;

    logic [7:0] field_x      [NUM_REQ];
    logic [6:0] field_y      [NUM_REQ];
    logic [2:0] field_colour [NUM_REQ];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_fields
            assign field_x[gi]      = req_x[8*gi +: 8];
            assign field_y[gi]      = req_y[7*gi +: 7];
            assign field_colour[gi] = req_colour[3*gi +: 3];
        end
    endgenerate

    // Last cycle's grantee may still be holding req while it reacts; mask it.
    assign eff      = req & ~grant;
    assign ptr_next = (pick_idx == PTR_LAST) ? '0 : pick_idx + 1'b1;

    rr_picker #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_rr_picker (
        .eff    (eff),
        .ptr    (ptr_reg),
        .winner (pick_idx),
        .valid  (pick_valid)
    );

    always_ff @(posedge CLOCK_50) begin
        if (!resetn) begin
            state_reg      <= ST_ARB;
            ptr_reg        <= '0;
            cx_reg         <= '0;
            cy_reg         <= '0;
            clear_last_reg <= 1'b0;
            grant          <= '0;
            clear_busy     <= 1'b0;
            clear_done     <= 1'b0;
            x              <= '0;
            y              <= '0;
            colour         <= '0;
            plot           <= 1'b0;
        end else begin
            clear_done <= 1'b0;
            grant      <= '0;
            case (state_reg)
                ST_ARB: begin
                    if (clear_start) begin
                        state_reg      <= ST_CLEAR;
                        cx_reg         <= '0;
                        cy_reg         <= '0;
                        clear_last_reg <= 1'b0;
                        plot           <= 1'b0;
                    end else if (pick_valid) begin
                        x       <= field_x[pick_idx];
                        y       <= field_y[pick_idx];
                        colour  <= field_colour[pick_idx];
                        plot    <= 1'b1;
                        grant   <= NUM_REQ'(1) << pick_idx;
                        ptr_reg <= ptr_next;
                    end else begin
                        plot <= 1'b0;
                    end
                end
                default: begin
                    // One extra cycle after the final pixel carries the done pulse.
                    if (clear_last_reg) begin
                        state_reg  <= ST_ARB;
                        clear_busy <= 1'b0;
                        clear_done <= 1'b1;
                        plot       <= 1'b0;
                    end else begin
                        x          <= cx_reg;
                        y          <= cy_reg;
                        colour     <= CLEAR_COLOUR;
                        plot       <= 1'b1;
                        clear_busy <= 1'b1;
                        if (cx_reg == CX_LAST) begin
                            cx_reg <= '0;
                            if (cy_reg == CY_LAST)
                                clear_last_reg <= 1'b1;
                            else
                                cy_reg <= cy_reg + 1'b1;
                        end else begin
                            cx_reg <= cx_reg + 1'b1;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: doc/plot_scheduler.md
Name: plot_scheduler

Overview:
- Shares the single vga_adapter plot port among NUM_REQ pixel requesters: player heads P1–P4 and the timer bar.
- Uses one-pixel-per-cycle round-robin arbitration.
- Provides a full-screen clear sweep for round start and restart.
- Sits between the game mechanics/timer logic and vga_adapter; its x, y, colour and plot outputs drive the adapter directly.

Parameters:
- NUM_REQ, 5, number of requesters (index 0..3 = P1..P4, 4 = timer).
- SCREEN_W, 160, pixels per row.
- SCREEN_H, 120, rows.
- CLEAR_COLOUR, 3'b000, colour written by the clear sweep.

Ports:
- CLOCK_50  in  1  system clock; all logic on its rising edge.
- resetn  in  1  synchronous active-low reset.
- req  in  NUM_REQ  per-requester plot request, held until granted.
- req_x  in  8*NUM_REQ  packed x coordinates; requester i uses bits [8i+7:8i].
- req_y  in  7*NUM_REQ  packed y coordinates; requester i uses bits [7i+6:7i].
- req_colour  in  3*NUM_REQ  packed colours; requester i uses bits [3i+2:3i].
- grant  out  NUM_REQ  one-hot, one-cycle grant, registered.
- clear_start  in  1  pulse that starts the clear sweep.
- clear_busy  out  1  high while the sweep runs.
- clear_done  out  1  one-cycle pulse when the sweep completes.
- x  out  8  plot x to vga_adapter.
- y  out  7  plot y to vga_adapter.
- colour  out  3  plot colour to vga_adapter.
- plot  out  1  plot strobe to vga_adapter.

Behaviour:
- Clock and reset: one clock, CLOCK_50. Reset is synchronous, active-low (resetn sampled on the CLOCK_50 rising edge).
- Reset values: x=0, y=0, colour=0, plot=0, grant=0, clear_busy=0, clear_done=0, round-robin pointer ptr=0, state ARB. Reset mid-sweep aborts the sweep; no clear_done pulse.
- All outputs are registered.

States:
- ARB
  - Effective request: eff = req & ~grant. Masking the requester granted last cycle prevents a double grant while it drops req.
  - If clear_start=1: go to CLEAR. This has priority over any eff bits; no grant that edge; plot=0.
  - Else if eff != 0: winner = first set bit of eff searching ptr, ptr+1, …, wrapping modulo NUM_REQ. On the edge:
    - x, y, colour = winner's fields
    - plot=1
    - grant = onehot(winner)
    - ptr = (winner+1) mod NUM_REQ
  - Else: plot=0, grant=0; x/y/colour hold their last values.
  - Latency: req sampled at edge k gives plot and grant high during cycle k→k+1.
- CLEAR
  - Counters cx (0..SCREEN_W-1) and cy (0..SCREEN_H-1) start at 0,0.
  - Each cycle: x=cx, y=cy, colour=CLEAR_COLOUR, plot=1, clear_busy=1, grant=0.
  - cx increments and wraps to 0 at SCREEN_W-1; cy then increments.
  - clear_busy is high for exactly SCREEN_W*SCREEN_H cycles (19200 at defaults).
  - After pixel (SCREEN_W-1, SCREEN_H-1): next edge sets clear_busy=0, plot=0, clear_done=1 for one cycle, state ARB, ptr unchanged.
  - req is ignored during CLEAR; pending requests are served in normal ARB order afterwards.
  - clear_start while clear_busy=1 is ignored.
- Widths: cx 8 bits, cy 7 bits; comparisons use the full-width constants SCREEN_W-1 and SCREEN_H-1. ptr is clog2(NUM_REQ) bits, with explicit wrap at NUM_REQ-1 (not power-of-two wrap).
- Requester contract: keep fields stable while req=1; drop req in the cycle grant is seen. Dropping req without a grant is legal; nothing is plotted for it.

Decomposition:
- Shared package (splatoon constants):
  - SCREEN_W, SCREEN_H
  - colour codes: COL_P1=3'b001, COL_P2=3'b010, COL_P3=3'b100, COL_P4=3'b110, COL_TIMER=3'b111, COL_BG=3'b000
  - requester indices REQ_P1..REQ_TIMER
  - state encoding ST_ARB, ST_CLEAR
- One sub-module: rr_picker. Combinational; inputs eff and ptr; outputs winner index and a valid flag. It is reused by the future RAM-port arbiter.

Test Plan:
- Reset: resetn=0 for 3 edges with req=5'b11111 and clear_start=1 → all outputs 0 throughout and one cycle after release.
- Single request: req=5'b00001, x=10, y=20, colour=001; the requester drops req on grant → exactly one cycle with plot=1, x=10, y=20, colour=001, grant=5'b00001.
- Fairness: req=5'b11111 held continuously with distinct coordinates → grants in order 00001, 00010, 00100, 01000, 10000, 00001, …; plot=1 every cycle; coordinates match the grantee.
- Clear sweep: clear_start pulse →
  - clear_busy high for exactly 19200 cycles
  - first pixel (0,0), pixel 160 = (0,1), last pixel (159,119), colour 000 throughout
  - then clear_done=1 for one cycle with plot=0.
- Collision: clear_start and req=5'b01000 on the same edge → no grant during the sweep; grant=5'b01000 with P4 coordinates on the first edge after clear_done.
- Reset mid-sweep: resetn=0 at pixel 5000 → outputs 0, no clear_done. After release, a new clear_start restarts at (0,0) and again takes 19200 cycles.
